// File: rtl/change_responder_pkg.sv
// Shared types, parameter limits and helpers for the change_responder stage.
package change_responder_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned LAT_MIN   = 1;
    localparam int unsigned LAT_MAX   = 3;

    typedef logic [WIDTH_DEF-1:0] data_t;

    // Response transform: captured value plus a constant, wrapping modulo 2^WIDTH.
    function automatic data_t apply_offset(data_t value, data_t offset);
        return value + offset;
    endfunction

endpackage

// File: rtl/change_responder_resp_fifo.sv
// Synchronous FIFO buffering responses while the output is held.
module resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A push at full is accepted when a pop frees the head slot in the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/change_responder.sv
// Emits input+OFFSET a fixed LAT edges after every sampled change of a_i,
// buffering responses in a small FIFO while hold_i is asserted.
module change_responder
    import change_responder_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned LAT    = 2,
    parameter int unsigned OFFSET = 1,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           a_i,
    input  logic                       hold_i,
    output logic [WIDTH-1:0]           b_o,
    output logic                       b_upd_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_o,
    output logic                       ovf_o,
    output logic                       busy_o
);

    if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
        $fatal(1, "change_responder: LAT=%0d outside %0d..%0d", LAT, LAT_MIN, LAT_MAX);
    end

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "change_responder: DEPTH=%0d must be a power of 2 and >= 2", DEPTH);
    end

    logic [WIDTH-1:0] a_q;
    logic             primed;
    logic             ev;
    logic [WIDTH-1:0] ev_data;
    logic             d_valid;
    logic [WIDTH-1:0] d_data;
    logic             dl_any;

    assign ev      = primed && (a_i != a_q);
    assign ev_data = a_i + WIDTH'(OFFSET);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            primed <= 1'b0;
        end else begin
            a_q    <= a_i;
            primed <= 1'b1;
        end
    end

    if (LAT == 1) begin : g_direct
        assign d_valid = ev;
        assign d_data  = ev_data;
        assign dl_any  = 1'b0;
    end else begin : g_delay
        // Packed shift chains: newest entry at the low end, delivery taken from the top.
        logic [LAT-2:0]         vld;
        logic [LAT-1:0]         vld_next;
        logic [(LAT-1)*WIDTH-1:0] dat;
        logic [LAT*WIDTH-1:0]     dat_next;

        assign vld_next = {vld, ev};
        assign dat_next = {dat, ev_data};

        always_ff @(posedge clk) begin
            if (rst) vld <= '0;
            else     vld <= vld_next[LAT-2:0];
        end

        always_ff @(posedge clk) begin
            dat <= dat_next[(LAT-1)*WIDTH-1:0];
        end

        assign d_valid = vld[LAT-2];
        assign d_data  = dat[(LAT-1)*WIDTH-1 -: WIDTH];
        assign dl_any  = |vld;
    end

    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             set_ovf;

    resp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (d_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending_o)
    );

    always_comb begin
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        load      = 1'b0;
        load_data = d_data;
        set_ovf   = 1'b0;
        if (!hold_i) begin
            if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                load      = 1'b1;
                load_data = fifo_head;
                fifo_push = d_valid;
            end else if (d_valid) begin
                load = 1'b1;
            end
        end else if (d_valid) begin
            if (fifo_full) set_ovf   = 1'b1;
            else           fifo_push = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_o     <= '0;
            b_upd_o <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            b_upd_o <= load;
            if (load)    b_o   <= load_data;
            if (set_ovf) ovf_o <= 1'b1;
        end
    end

    assign busy_o = dl_any || (pending_o != '0);

endmodule

// File: tb/tb_change_responder.sv
// Bench for change_responder: LAT=2 and LAT=1 instances share stimulus and are
// compared every cycle against a timestamp/queue model of the response stream.
module tb_change_responder;

    localparam int unsigned W      = 8;
    localparam int unsigned OFFSET = 1;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PW     = $clog2(DEPTH+1);
    localparam int          LATS [2] = '{2, 1};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hold_i = 1'b0;
    logic [W-1:0]  a_i = '0;

    logic [W-1:0]  b2, b1;
    logic          upd2, upd1, ovf2, ovf1, busy2, busy1;
    logic [PW-1:0] pend2, pend1;
    logic [W+PW+2:0] obs [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    change_responder #(.WIDTH(W), .LAT(2), .OFFSET(OFFSET), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .a_i(a_i), .hold_i(hold_i),
        .b_o(b2), .b_upd_o(upd2), .pending_o(pend2), .ovf_o(ovf2), .busy_o(busy2)
    );

    change_responder #(.WIDTH(W), .LAT(1), .OFFSET(OFFSET), .DEPTH(DEPTH)) dut_lat1 (
        .clk(clk), .rst(rst), .a_i(a_i), .hold_i(hold_i),
        .b_o(b1), .b_upd_o(upd1), .pending_o(pend1), .ovf_o(ovf1), .busy_o(busy1)
    );

    assign obs[0] = {b2, upd2, pend2, ovf2, busy2};
    assign obs[1] = {b1, upd1, pend1, ovf1, busy1};

    // Model: each event is a (due edge, value) pair; delivery rules act on a bounded queue.
    int unsigned  edge_no = 0;
    logic [W-1:0] m_prev   [2];
    bit           m_primed [2];
    int unsigned  m_due    [2][$];
    logic [W-1:0] m_val    [2][$];
    logic [W-1:0] m_fifo   [2][$];
    logic [W-1:0] m_b      [2];
    bit           m_upd    [2];
    bit           m_ovf    [2];

    task automatic model_edge(input int m, input logic [W-1:0] a, input bit h, input bit r);
        logic [W-1:0] d;
        bit dv;
        if (r) begin
            m_due[m].delete();
            m_val[m].delete();
            m_fifo[m].delete();
            m_b[m] = '0;
            m_upd[m] = 0;
            m_ovf[m] = 0;
            m_primed[m] = 0;
            m_prev[m] = '0;
            return;
        end
        if (m_primed[m] && a != m_prev[m]) begin
            m_due[m].push_back(edge_no + LATS[m] - 1);
            m_val[m].push_back(W'(a + OFFSET));
        end
        dv = 0;
        d = '0;
        if (m_due[m].size() > 0 && m_due[m][0] == edge_no) begin
            dv = 1;
            d = m_val[m].pop_front();
            void'(m_due[m].pop_front());
        end
        m_upd[m] = 0;
        if (!h) begin
            if (m_fifo[m].size() > 0) begin
                m_b[m] = m_fifo[m].pop_front();
                m_upd[m] = 1;
                if (dv) m_fifo[m].push_back(d);
            end else if (dv) begin
                m_b[m] = d;
                m_upd[m] = 1;
            end
        end else if (dv) begin
            if (m_fifo[m].size() == DEPTH) m_ovf[m] = 1;
            else m_fifo[m].push_back(d);
        end
        m_prev[m] = a;
        m_primed[m] = 1;
    endtask

    function automatic logic [W+PW+2:0] expv(input int m);
        bit busy;
        busy = (m_due[m].size() != 0) || (m_fifo[m].size() != 0);
        return {m_b[m], m_upd[m], PW'(m_fifo[m].size()), m_ovf[m], busy};
    endfunction

    task automatic step(input logic [W-1:0] a, input bit h, input bit r);
        a_i = a;
        hold_i = h;
        rst = r;
        @(posedge clk);
        edge_no++;
        model_edge(0, a, h, r);
        model_edge(1, a, h, r);
        #1;
    endtask

    task automatic test_reset;
        for (int n = 0; n < 2; n++) begin
            step(8'h00, 0, 1);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== '0) begin
                    errors++;
                    $display("FAIL reset lat%0d: got %h expected 0", LATS[m], obs[m]);
                end
            end
        end
    endtask

    task automatic test_idle;
        for (int n = 0; n < 10; n++) begin
            step(8'h10, 0, 0);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== expv(m)) begin
                    errors++;
                    $display("FAIL idle lat%0d cyc%0d: got %h expected %h", LATS[m], n, obs[m], expv(m));
                end
            end
        end
        checks++;
        if ({upd2, b2, busy2, upd1, b1, busy1} !== '0) begin
            errors++;
            $display("FAIL idle_quiet: got upd/b/busy %b %h %b / %b %h %b expected all 0",
                     upd2, b2, busy2, upd1, b1, busy1);
        end
    endtask

    task automatic test_single_change;
        logic [W:0] want2 [3];
        logic [W:0] want1 [3];
        want2 = '{{1'b0, 8'h00}, {1'b1, 8'h21}, {1'b0, 8'h21}};
        want1 = '{{1'b1, 8'h21}, {1'b0, 8'h21}, {1'b0, 8'h21}};
        for (int n = 0; n < 3; n++) begin
            step(8'h20, 0, 0);
            checks++;
            if ({upd2, b2} !== want2[n]) begin
                errors++;
                $display("FAIL single_lat2 cyc%0d: got %h expected %h", n, {upd2, b2}, want2[n]);
            end
            checks++;
            if ({upd1, b1} !== want1[n]) begin
                errors++;
                $display("FAIL single_lat1 cyc%0d: got %h expected %h", n, {upd1, b1}, want1[n]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] seq [6];
        logic [W:0]   want2 [6];
        seq   = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03};
        want2 = '{{1'b0, 8'h21}, {1'b1, 8'h02}, {1'b1, 8'h03}, {1'b1, 8'h04},
                  {1'b0, 8'h04}, {1'b0, 8'h04}};
        for (int n = 0; n < 6; n++) begin
            step(seq[n], 0, 0);
            checks++;
            if ({upd2, b2} !== want2[n]) begin
                errors++;
                $display("FAIL b2b_lat2 cyc%0d: got %h expected %h", n, {upd2, b2}, want2[n]);
            end
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== expv(m)) begin
                    errors++;
                    $display("FAIL b2b lat%0d cyc%0d: got %h expected %h", LATS[m], n, obs[m], expv(m));
                end
            end
        end
    endtask

    task automatic test_hold_overflow;
        logic [W-1:0] seq [8];
        logic [W-1:0] drain [4];
        seq   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h06, 8'h06};
        drain = '{8'h02, 8'h03, 8'h04, 8'h05};
        for (int n = 0; n < 8; n++) begin
            step(seq[n], 1, 0);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== expv(m)) begin
                    errors++;
                    $display("FAIL hold lat%0d cyc%0d: got %h expected %h", LATS[m], n, obs[m], expv(m));
                end
            end
        end
        checks++;
        if ({pend2, ovf2, pend1, ovf1} !== {3'd4, 1'b1, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL hold_saturate: got pend/ovf %0d %b / %0d %b expected 4 1 / 4 1",
                     pend2, ovf2, pend1, ovf1);
        end
        for (int n = 0; n < 5; n++) begin
            step(8'h06, 0, 0);
            checks++;
            if (n < 4 && ({upd2, b2, upd1, b1} !== {1'b1, drain[n], 1'b1, drain[n]})) begin
                errors++;
                $display("FAIL drain cyc%0d: got %b %h / %b %h expected 1 %h", n, upd2, b2, upd1, b1, drain[n]);
            end
            if (n == 4 && ({upd2, upd1, ovf2, ovf1} !== 4'b0011)) begin
                errors++;
                $display("FAIL drain_end: got upd %b%b ovf %b%b expected upd 00 ovf 11", upd2, upd1, ovf2, ovf1);
            end
        end
    endtask

    task automatic test_reset_midflight;
        step(8'h40, 1, 0);
        step(8'h41, 1, 0);
        step(8'h41, 0, 1);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m] !== '0) begin
                errors++;
                $display("FAIL midreset lat%0d: got %h expected 0", LATS[m], obs[m]);
            end
        end
        for (int n = 0; n < 4; n++) begin
            step(8'h41, 0, 0);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== expv(m) || obs[m] !== '0) begin
                    errors++;
                    $display("FAIL post_reset lat%0d cyc%0d: got %h expected 0", LATS[m], n, obs[m]);
                end
            end
        end
    endtask

    task automatic test_lat1_wrap;
        step(8'hFF, 0, 0);
        checks++;
        if ({upd1, b1} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL wrap_lat1: got %b %h expected 1 00", upd1, b1);
        end
        step(8'hFF, 0, 0);
        checks++;
        if ({upd2, b2} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL wrap_lat2: got %b %h expected 1 00", upd2, b2);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        bit h, r;
        a = 8'hFF;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0) a = W'($urandom);
            h = ($urandom_range(0, 99) < 35);
            r = ($urandom_range(0, 99) < 2);
            step(a, h, r);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== expv(m)) begin
                    errors++;
                    $display("FAIL random lat%0d cyc%0d: got %h expected %h", LATS[m], n, obs[m], expv(m));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_change();
        test_back_to_back();
        test_hold_overflow();
        test_reset_midflight();
        test_lat1_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_responder.md
Name: change_responder

Overview:
- DUT-side stage that produces the response stream checked by the team's change/response SVA checkers.
- Watches an input data word. Every sampled change produces one transformed response word (input + OFFSET) on the output after a fixed latency LAT, so that "$changed(a_i) |-> ##[1:3] $changed(b_o)" holds whenever the output is not held.
- While hold_i is asserted, responses are buffered in a small FIFO.

Parameters:
- WIDTH, 8, data width of a_i and b_o.
- LAT, 2, edges from change detection to b_o update; legal range 1..3. Out-of-range values must be rejected by an elaboration-time $fatal.
- OFFSET, 1, constant added to the captured value, modulo 2^WIDTH.
- DEPTH, 4, hold FIFO depth; must be at least 2 and a power of 2.

Ports:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- a_i, in, WIDTH, monitored data.
- hold_i, in, 1, 1 = do not update b_o; buffer responses instead.
- b_o, out, WIDTH, current response value (registered).
- b_upd_o, out, 1, one-cycle pulse in the cycle b_o takes a new value.
- pending_o, out, $clog2(DEPTH+1), FIFO occupancy.
- ovf_o, out, 1, sticky flag: a response was dropped because the FIFO was full.
- busy_o, out, 1, high if any delay stage is valid or pending_o != 0.

Behaviour:
- Reset:
  - One clock, synchronous, active-high.
  - While rst is high at an edge: b_o=0, b_upd_o=0, pending_o=0, ovf_o=0, busy_o=0.
  - All delay-line valid bits, FIFO pointers, a_q and primed are cleared.
  - Applying rst mid-operation discards all in-flight and buffered responses; none is ever emitted.
- Change detect:
  - a_q samples a_i every edge. primed is set on the first edge after reset.
  - An event fires at edge N iff primed && a_i != a_q. The value a_i+OFFSET (truncated to WIDTH) is captured.
  - The first edge after reset never fires an event.
- Delay line:
  - LAT-1 valid/data stages. An event at edge N reaches the delivery point at edge N+LAT-1.
  - For LAT=1 the event feeds delivery directly.
- Delivery, evaluated each edge with input d (delay-line output, valid or not):
  - hold_i=0, FIFO empty, d valid: b_o<=d, b_upd_o<=1.
  - hold_i=0, FIFO non-empty: pop head into b_o, b_upd_o<=1. If d is valid, push d in the same edge; push and pop at full is legal and does not overflow.
  - hold_i=1: if d is valid, push d. If the FIFO is full, drop d and set ovf_o<=1.
  - Otherwise b_upd_o<=0 and b_o holds.
- Latency guarantee:
  - With hold_i=0 and the FIFO empty, b_o changes right after edge N+LAT-1, so $changed(b_o) is sampled at edge N+LAT.
  - Order is strictly preserved.
  - Consecutively emitted values always differ unless a drop occurred.
- ovf_o clears only on rst.

Decomposition:
- Package change_responder_pkg:
  - WIDTH_DEF, LAT_MIN=1, LAT_MAX=3.
  - typedef logic [WIDTH_DEF-1:0] data_t.
  - Function apply_offset(data_t, data_t).
- One natural sub-module: resp_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterised by WIDTH and DEPTH, with synchronous active-high reset.
- Change detection, delay line and delivery mux stay in the top module.

Test Plan (LAT=2, OFFSET=1, DEPTH=4 unless stated):
1. Release rst, hold a_i=0x10 for 10 cycles -> b_upd_o never pulses; b_o=0x00; busy_o=0.
2. a_i goes 0x10->0x20, sampled at edge N -> b_o=0x21 after edge N+1; b_upd_o high for exactly that one cycle; the SVA ##[1:3] checker passes.
3. a_i changes every cycle 0x01,0x02,0x03 -> b_o shows 0x02,0x03,0x04 on consecutive cycles, each with b_upd_o=1.
4. Sequence of holds and changes:
   - hold_i=1 for 8 cycles while a_i changes 6 times (0x01..0x06) -> pending_o saturates at 4 and ovf_o=1.
   - Release hold_i -> 0x02,0x03,0x04,0x05 emerge one per cycle.
   - ovf_o stays 1.
5. Two changes in flight, then rst for one cycle -> after that edge all outputs are 0; no b_upd_o for the discarded values; the first edge after rst produces no event.
6. LAT=1 with a_i=0xFF sampled changed at edge N -> b_o=0x00 (wrap) immediately after edge N. Separately, elaborating with LAT=4 triggers $fatal.
